// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default sizing for the fetch/commit sequencer.
package fetch_ctrl_pkg;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_TIMEOUT = 16;

   // Instruction life cycle: boot, fetch request, fetch response, execute,
   // load/store wait, debug park, and the absorbing fetch-timeout fault.
   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_MEM   = 3'd4,
      S_HALT  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

endpackage

// File: rtl/fetch_ctrl_perf_cnt.sv
// Free-running wrap-around event counter with synchronous active-low clear.
module perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Clear wins over increment; the count wraps naturally at 2^CNT_W.
   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: walks each instruction through fetch, execute and an optional
// load/store wait, issues the PC commit strobe, and handles debug halt/step.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   output logic             o_imem_req,
   input  logic             i_imem_ready,
   input  logic             i_imem_rvalid,
   input  logic             i_lsu_busy,
   input  logic             i_br_taken,
   input  logic             i_halt_req,
   input  logic             i_step_req,
   output logic             o_insn_vld,
   output logic             o_pc_en,
   output logic             o_pc_sel,
   output logic             o_halted,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_instret
);

   localparam int              TO_W    = $clog2(TIMEOUT + 1);
   // Last WAIT cycle index that may still see the response before faulting.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          r_state;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_step;

   logic            w_in_insn;
   logic            w_commit;
   logic            w_cyc_inc;

   // EXEC and MEM both hold a live instruction; it retires once the LSU is idle.
   assign w_in_insn = (r_state == S_EXEC) || (r_state == S_MEM);
   assign w_commit  = w_in_insn && !i_lsu_busy;
   assign w_cyc_inc = (r_state != S_HALT) && (r_state != S_FAULT);

   // Sequencer state, fetch timeout counter and single-step flag.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state  <= S_BOOT;
         r_to_cnt <= '0;
         r_step   <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state <= i_halt_req ? S_HALT : S_REQ;
            end
            S_REQ: begin
               // A stray rvalid here is ignored; only the handshake advances.
               if (i_imem_ready) begin
                  r_state  <= S_WAIT;
                  r_to_cnt <= '0;
               end
            end
            S_WAIT: begin
               // A response on the final allowed cycle still beats the timeout.
               if (i_imem_rvalid) begin
                  r_state <= S_EXEC;
               end else if (r_to_cnt == TO_LAST) begin
                  r_state <= S_FAULT;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            S_EXEC, S_MEM: begin
               if (!i_lsu_busy) begin
                  r_state <= (i_halt_req || r_step) ? S_HALT : S_REQ;
                  r_step  <= 1'b0;
               end else begin
                  r_state <= S_MEM;
               end
            end
            S_HALT: begin
               if (i_step_req) begin
                  r_step  <= 1'b1;
                  r_state <= S_REQ;
               end else if (!i_halt_req) begin
                  r_step  <= 1'b0;
                  r_state <= S_REQ;
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign o_imem_req = (r_state == S_REQ);
   assign o_insn_vld = w_in_insn;
   assign o_halted   = (r_state == S_HALT);
   assign o_fault    = (r_state == S_FAULT);
   assign o_pc_en    = w_commit;
   assign o_pc_sel   = w_commit && i_br_taken;

   perf_cnt #(
      .CNT_W (CNT_W)
   ) u_cycle_cnt (
      .i_clk   (i_clk),
      .i_clr_n (i_rst),
      .i_inc   (w_cyc_inc),
      .o_cnt   (o_cycle_cnt)
   );

   perf_cnt #(
      .CNT_W (CNT_W)
   ) u_instret_cnt (
      .i_clk   (i_clk),
      .i_clr_n (i_rst),
      .i_inc   (w_commit),
      .o_cnt   (o_instret)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a per-cycle driver with planned
// expectations plus a commit scoreboard filled when instructions are issued.
module tb_fetch_ctrl;

   localparam int CNT_W   = 32;
   localparam int TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst, rdy, rv, lsu, br, halt, step;
   logic             o_imem_req, o_insn_vld, o_pc_en, o_pc_sel, o_halted, o_fault;
   logic [CNT_W-1:0] o_cycle_cnt, o_instret;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_imem_req    (o_imem_req),
      .i_imem_ready  (rdy),
      .i_imem_rvalid (rv),
      .i_lsu_busy    (lsu),
      .i_br_taken    (br),
      .i_halt_req    (halt),
      .i_step_req    (step),
      .o_insn_vld    (o_insn_vld),
      .o_pc_en       (o_pc_en),
      .o_pc_sel      (o_pc_sel),
      .o_halted      (o_halted),
      .o_fault       (o_fault),
      .o_cycle_cnt   (o_cycle_cnt),
      .o_instret     (o_instret)
   );

   typedef struct {
      int   cyc;
      int   cc;
      int   ir;
      logic sel;
   } sb_t;

   sb_t  sb_q[$];
   int   n_chk      = 0;
   int   n_fail     = 0;
   int   cyc_no     = 0;
   int   exp_active = 0;
   int   exp_ir     = 0;
   logic g_halt     = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
   task automatic cyc(input logic r, input logic a_rdy, input logic a_rv, input logic a_lsu,
                      input logic a_br, input logic a_halt, input logic a_step,
                      input bit active, input bit commit);
      sb_t e;
      @(negedge clk);
      rst = r; rdy = a_rdy; rv = a_rv; lsu = a_lsu; br = a_br; halt = a_halt; step = a_step;
      #1;
      chk("pc_en", o_pc_en, commit);
      chk("cycle_cnt", o_cycle_cnt, exp_active);
      chk("instret", o_instret, exp_ir);
      if (o_pc_en === 1'b1) begin
         chk("sb_nonempty", sb_q.size() != 0, 1'b1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("commit_cycle", cyc_no, e.cyc);
            chk("commit_sel", o_pc_sel, e.sel);
            chk("commit_cc", o_cycle_cnt, e.cc);
            chk("commit_ir", o_instret, e.ir);
            $display("commit cycle=%0d sel=%0b instret=%0d cycles=%0d",
                     cyc_no, o_pc_sel, o_instret, o_cycle_cnt);
         end
      end else begin
         chk("pc_sel_idle", o_pc_sel, 1'b0);
      end
      if (!r) begin
         exp_active = 0;
         exp_ir     = 0;
      end else begin
         if (active) exp_active++;
         if (commit) exp_ir++;
      end
      cyc_no++;
   endtask

   // One instruction starting in REQ: req_w stall cycles, rv_w missing-response
   // cycles, mem_w busy cycles in EXEC/MEM, then the commit.
   task automatic run_insn(input int req_w, input int rv_w, input int mem_w,
                           input logic br_v, input bit halt_in_wait);
      sb_t e;
      int  off;
      off   = req_w + rv_w + mem_w + 2;
      e.cyc = cyc_no + off;
      e.cc  = exp_active + off;
      e.ir  = exp_ir;
      e.sel = br_v;
      sb_q.push_back(e);
      for (int i = 0; i < req_w; i++) begin
         cyc(1, 0, 1, 1, 1, g_halt, 1, 1, 0);
         chk("req_hold", o_imem_req, 1'b1);
      end
      cyc(1, 1, 1, 0, 0, g_halt, 0, 1, 0);
      chk("req", o_imem_req, 1'b1);
      if (halt_in_wait) g_halt = 1'b1;
      for (int i = 0; i < rv_w; i++) begin
         cyc(1, 0, 0, 1, 1, g_halt, 0, 1, 0);
         chk("wait_req", o_imem_req, 1'b0);
         chk("wait_vld", o_insn_vld, 1'b0);
      end
      cyc(1, 0, 1, 0, 0, g_halt, 0, 1, 0);
      chk("wait_vld", o_insn_vld, 1'b0);
      for (int i = 0; i < mem_w; i++) begin
         cyc(1, 0, 0, 1, ~br_v, g_halt, 0, 1, 0);
         chk("mem_vld", o_insn_vld, 1'b1);
      end
      cyc(1, 0, 0, 0, br_v, g_halt, 0, 1, 1);
      chk("exec_vld", o_insn_vld, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0; rdy = 0; rv = 0; lsu = 0; br = 0; halt = 0; step = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_imem_req", o_imem_req, 1'b0);
      chk("rst_insn_vld", o_insn_vld, 1'b0);
      chk("rst_pc_en", o_pc_en, 1'b0);
      chk("rst_pc_sel", o_pc_sel, 1'b0);
      chk("rst_halted", o_halted, 1'b0);
      chk("rst_fault", o_fault, 1'b0);
      chk("rst_cycle_cnt", o_cycle_cnt, 0);
      chk("rst_instret", o_instret, 0);

      // BOOT cycle
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("boot_req", o_imem_req, 1'b0);

      // Back-to-back 3-cycle instructions: commit every third cycle
      repeat (4) run_insn(0, 0, 0, 1'b0, 0);
      // Two LSU busy cycles with a taken branch: 5-cycle instruction
      run_insn(0, 0, 2, 1'b1, 0);
      // Ignored rvalid while stalled in REQ, response on the last allowed WAIT cycle
      run_insn(2, TIMEOUT - 1, 1, 1'b1, 0);

      // Halt raised mid-WAIT: instruction completes, then parks
      run_insn(0, 1, 0, 1'b0, 1);
      repeat (3) begin
         cyc(1, 1, 1, 0, 0, 1, 0, 0, 0);
         chk("halted", o_halted, 1'b1);
         chk("halt_no_req", o_imem_req, 1'b0);
      end
      // Single step while halt held: exactly one instruction, then back to HALT
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
      chk("step_halted", o_halted, 1'b1);
      run_insn(0, 0, 0, 1'b1, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("after_step_halted", o_halted, 1'b1);
      g_halt = 1'b0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("release_halted", o_halted, 1'b1);
      run_insn(0, 0, 0, 1'b0, 0);
      run_insn(1, 0, 0, 1'b0, 0);

      // Reset while in MEM: no commit, reset values on the next cycle
      cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1, 0, 0, 1, 0);
      chk("mem_vld_at_rst", o_insn_vld, 1'b1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("post_rst_req", o_imem_req, 1'b0);
      chk("post_rst_vld", o_insn_vld, 1'b0);
      chk("post_rst_halted", o_halted, 1'b0);
      chk("post_rst_fault", o_fault, 1'b0);
      run_insn(0, 0, 0, 1'b1, 0);

      // Fetch timeout: exactly TIMEOUT WAIT cycles without rvalid
      cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
      chk("to_req", o_imem_req, 1'b1);
      for (int i = 0; i < TIMEOUT; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
         chk("to_wait_fault", o_fault, 1'b0);
         chk("to_wait_req", o_imem_req, 1'b0);
      end
      repeat (3) begin
         cyc(1, 1, 1, 0, 1, 1, 1, 0, 0);
         chk("fault", o_fault, 1'b1);
         chk("fault_req", o_imem_req, 1'b0);
         chk("fault_vld", o_insn_vld, 1'b0);
         chk("fault_halted", o_halted, 1'b0);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("fault_until_rst", o_fault, 1'b1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("fault_cleared", o_fault, 1'b0);
      chk("fault_rst_req", o_imem_req, 1'b0);
      run_insn(0, 0, 0, 1'b0, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
